// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULT/MULTU/DIV/DIVU engine that owns the HI/LO registers
module muldiv_seq #(
  parameter int MULT_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi_en,
  input  logic        mtlo_en,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  // MUL occupies LATENCY-1 busy cycles; the final HI/LO write lands one edge later from IDLE
  localparam logic [5:0] MUL_LAST = 6'(MULT_LATENCY > 1 ? MULT_LATENCY - 2 : 0);
  localparam bit MUL_DIRECT = MULT_LATENCY == 1;
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic sa_q, sa_d, sb_q, sb_d, wb_q, wb_d, done_q, done_d;
  logic [31:0] ma_q, ma_d, mb_q, mb_d, rem_q, rem_d, quo_q, quo_d, hi_q, hi_d, lo_q, lo_d;
  logic [63:0] prod_u, prod;
  logic [32:0] r_sh, diff;
  // magnitude product with the result sign applied afterwards
  always_comb begin
    prod_u = {32'd0, ma_q} * {32'd0, mb_q};
    prod = (sa_q ^ sb_q) ? -prod_u : prod_u;
  end
  // one restoring-division step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    r_sh = {rem_q, quo_q[31]};
    diff = r_sh - {1'b0, mb_q};
  end
  // next-state, datapath and HI/LO update
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sa_d = sa_q;
    sb_d = sb_q;
    ma_d = ma_q;
    mb_d = mb_q;
    rem_d = rem_q;
    quo_d = quo_q;
    hi_d = hi_q;
    lo_d = lo_q;
    wb_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb_q) begin
          {hi_d, lo_d} = prod;
          done_d = 1'b1;
        end
        if (start) begin
          sa_d = ~op[0] & a[31];
          sb_d = ~op[0] & b[31];
          ma_d = sa_d ? -a : a;
          mb_d = sb_d ? -b : b;
          quo_d = ma_d;
          rem_d = '0;
          cnt_d = '0;
          wb_d = ~op[1] & MUL_DIRECT;
          state_d = op[1] ? DIV : (MUL_DIRECT ? IDLE : MUL);
        end else begin
          hi_d = mthi_en ? wdata : hi_d;
          lo_d = mtlo_en ? wdata : lo_d;
        end
      end
      MUL: begin
        cnt_d = cnt_q + 6'd1;
        wb_d = cnt_q == MUL_LAST;
        state_d = (cnt_q == MUL_LAST) ? IDLE : MUL;
      end
      DIV: begin
        rem_d = diff[32] ? r_sh[31:0] : diff[31:0];
        quo_d = {quo_q[30:0], ~diff[32]};
        cnt_d = cnt_q + 6'd1;
        state_d = (cnt_q == 6'd31) ? FIX : DIV;
      end
      FIX: begin
        lo_d = (sa_q ^ sb_q) ? -quo_q : quo_q;
        hi_d = sa_q ? -rem_q : rem_q;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared by asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      ma_q <= '0;
      mb_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      wb_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      ma_q <= ma_d;
      mb_q <= mb_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      wb_q <= wb_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for the HI/LO multiply/divide sequencer
module tb_muldiv_seq;
  localparam int L = 3;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, mthi_en = 1'b0, mtlo_en = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  int n_assert = 0, n_fail = 0;
  typedef struct {string name; logic [31:0] hi; logic [31:0] lo;} exp_t;
  exp_t exp_queue[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  muldiv_seq #(.MULT_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi_en(mthi_en), .mtlo_en(mtlo_en), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_queue.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL spurious_done: done=1 with no result outstanding, required done=0");
      end else begin
        mon_e = exp_queue.pop_front();
        chk({mon_e.name, "_hi"}, hi, mon_e.hi);
        chk({mon_e.name, "_lo"}, lo, mon_e.lo);
      end
    end
  end

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input int lat, input int bsy, input bit inject);
    int k;
    int nb;
    bit seen;
    k = 0;
    seen = 1'b0;
    exp_queue.push_back('{name, eh, el});
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mthi_en = 1'b0;
    a = 32'hA5A5A5A5;
    b = 32'h5A5A5A5A;
    nb = int'(busy);
    while (!seen && k < 60) begin
      if (inject && k == 5) begin
        start = 1'b1;
        op = 2'b01;
        a = 32'd2;
        b = 32'd2;
        mtlo_en = 1'b1;
        wdata = 32'h12345678;
      end
      @(posedge clk);
      #1;
      k++;
      start = 1'b0;
      mtlo_en = 1'b0;
      nb += int'(busy);
      if (done) seen = 1'b1;
    end
    chk({name, "_latency"}, 32'(k), 32'(lat));
    chk({name, "_busy_cycles"}, 32'(nb), 32'(bsy));
  endtask

  initial begin
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, L, L - 1, 1'b0);
    run_op("mult_neg3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, L, L - 1, 1'b0);
    run_op("mult_min_sq", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, L, L - 1, 1'b0);
    run_op("mult_neg_neg", 2'b00, 32'hFFFFFFFC, 32'hFFFFFFFB, 32'h00000000, 32'h00000014, L, L - 1, 1'b0);
    run_op("div_neg7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 33, 1'b0);
    run_op("div_overflow", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 33, 1'b0);
    run_op("divu_by_zero", 2'b11, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, 33, 33, 1'b0);
    run_op("div_neg_by_zero", 2'b10, 32'hFFFFFF9C, 32'd0, 32'hFFFFFF9C, 32'h00000001, 33, 33, 1'b0);
    run_op("div_7_neg2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 33, 1'b0);
    run_op("divu_max_16", 2'b11, 32'hFFFFFFFF, 32'd16, 32'h0000000F, 32'h0FFFFFFF, 33, 33, 1'b0);
    run_op("divu_ignore_req", 2'b11, 32'd1000, 32'd7, 32'h00000006, 32'h0000008E, 33, 33, 1'b1);
    mthi_en = 1'b1;
    wdata = 32'hDEADBEEF;
    run_op("start_beats_mthi", 2'b01, 32'd3, 32'd4, 32'h00000000, 32'h0000000C, L, L - 1, 1'b0);
    mtlo_en = 1'b1;
    wdata = 32'h12345678;
    @(posedge clk);
    #1;
    mtlo_en = 1'b0;
    chk("mtlo_lo", lo, 32'h12345678);
    chk("mtlo_hi_kept", hi, 32'h00000000);
    chk("mtlo_no_done", 32'(done), 32'd0);
    mthi_en = 1'b1;
    mtlo_en = 1'b1;
    wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    mthi_en = 1'b0;
    mtlo_en = 1'b0;
    chk("mt_both_hi", hi, 32'hCAFEF00D);
    chk("mt_both_lo", lo, 32'hCAFEF00D);
    op = 2'b10;
    a = 32'hFFFFFFF9;
    b = 32'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_idle_busy", 32'(busy), 32'd0);
    chk("abort_idle_lo", lo, 32'd0);
    run_op("divu_9_4", 2'b11, 32'd9, 32'd4, 32'h00000001, 32'h00000002, 33, 33, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_queue.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
